draw_rect_overlay: RTL

- Consumer end of the mouse/animation position path. Takes the xpos/ypos stream from the position controller and overlays a fixed-size rectangle on the VGA timing/pixel stream.
- Sits between the background generator and the VGA output register.
- Latches the position once per frame, at vblank start, so the rectangle never tears.
- Delays all timing signals to match a 2-stage pixel pipeline.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_delay.sv | 39 +++
 rtl/draw_rect_overlay.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA pipeline definitions.
//   Widths for pixel counters, positions and 4:4:4 colour, visible area
//   size, and the timing bundle carried alongside every pixel.
package vga_pkg;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned POS_W    = 12;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned VIS_W    = 800;
    localparam int unsigned VIS_H    = 600;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [HCOUNT_W-1:0] vcount;
        logic                hsync;
        logic                vsync;
        logic                hblnk;
        logic                vblnk;
    } timing_t;

endpackage

// File: rtl/vga_timing_delay.sv
// vga_timing_delay: N-stage register chain for the VGA timing bundle.
//   pclk       in   pixel clock
//   rst        in   synchronous reset, active-high (clears every stage)
//   timing_in  in   timing bundle
//   timing_out out  timing_in delayed N cycles
module vga_timing_delay
    import vga_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic    pclk,
    input  logic    rst,
    input  timing_t timing_in,
    output timing_t timing_out
);

    timing_t stage_q [N];
    timing_t stage_d [N];

    always_comb begin
        stage_d[0] = timing_in;
        for (int unsigned i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge pclk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign timing_out = stage_q[N-1];

endmodule

// File: rtl/draw_rect_overlay.sv
// draw_rect_overlay: overlays a fixed-size rectangle on the VGA pixel stream.
//   Position (xpos/ypos) is captured once per frame on the first cycle of
//   vertical blanking so the rectangle never tears. Two-stage pipeline:
//   stage 1 registers inputs and the hit test, stage 2 composites.
//   Optional macro DRAW_RECT_BORDER_EN: draw only a BORDER_W-thick outline.
// Ports:
//   pclk, rst                    clock, synchronous active-high reset
//   xpos, ypos                   rectangle top-left corner
//   hcount_in..vblnk_in, rgb_in  incoming timing and background pixel
//   hcount_out..vblnk_out        timing delayed 2 cycles
//   rgb_out                      composited pixel, 2-cycle latency
module draw_rect_overlay
    import vga_pkg::*;
#(
    parameter int unsigned      RECT_W     = 48,
    parameter int unsigned      RECT_H     = 64,
    parameter logic [RGB_W-1:0] RECT_COLOR = 12'hF_0_0,
    parameter int unsigned      BORDER_W   = 2
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [POS_W-1:0]    xpos,
    input  logic [POS_W-1:0]    ypos,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [HCOUNT_W-1:0] vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                hblnk_in,
    input  logic                vblnk_in,
    input  logic [RGB_W-1:0]    rgb_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [HCOUNT_W-1:0] vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                hblnk_out,
    output logic                vblnk_out,
    output logic [RGB_W-1:0]    rgb_out
);

    // One bit wider than a position so edge sums never wrap.
    localparam int unsigned SUM_W = POS_W + 1;

`ifdef DRAW_RECT_BORDER_EN
    localparam logic OUTLINE_ONLY = 1'b1;
`else
    localparam logic OUTLINE_ONLY = 1'b0;
`endif

    logic [POS_W-1:0] x_lat_q, x_lat_d;
    logic [POS_W-1:0] y_lat_q, y_lat_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    logic [RGB_W-1:0] rgb_s1_q, rgb_s1_d;
    logic             blank_s1_q, blank_s1_d;
    logic             hit_s1_q, hit_s1_d;
    logic [RGB_W-1:0] rgb_out_q, rgb_out_d;

    logic [SUM_W-1:0] h_ext, v_ext, x_ext, y_ext;
    logic             in_rect, on_border;

    timing_t timing_in, timing_out;

    always_comb begin
        vblnk_prev_d = vblnk_in;
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        if (vblnk_in && !vblnk_prev_q) begin
            x_lat_d = xpos;
            y_lat_d = ypos;
        end
    end

    // Hit test uses the latch value before any update on this same cycle.
    always_comb begin
        h_ext = {2'b00, hcount_in};
        v_ext = {2'b00, vcount_in};
        x_ext = {1'b0, x_lat_q};
        y_ext = {1'b0, y_lat_q};

        in_rect   = (h_ext >= x_ext) && (h_ext < x_ext + SUM_W'(RECT_W)) &&
                    (v_ext >= y_ext) && (v_ext < y_ext + SUM_W'(RECT_H));
        on_border = (h_ext <  x_ext + SUM_W'(BORDER_W)) ||
                    (h_ext >= x_ext + SUM_W'(RECT_W - BORDER_W)) ||
                    (v_ext <  y_ext + SUM_W'(BORDER_W)) ||
                    (v_ext >= y_ext + SUM_W'(RECT_H - BORDER_W));

        hit_s1_d   = in_rect && (on_border || !OUTLINE_ONLY);
        rgb_s1_d   = rgb_in;
        blank_s1_d = hblnk_in || vblnk_in;
    end

    always_comb begin
        rgb_out_d = rgb_s1_q;
        if (blank_s1_q) begin
            rgb_out_d = '0;
        end else if (hit_s1_q) begin
            rgb_out_d = RECT_COLOR;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            vblnk_prev_q <= 1'b0;
            rgb_s1_q     <= '0;
            blank_s1_q   <= 1'b0;
            hit_s1_q     <= 1'b0;
            rgb_out_q    <= '0;
        end else begin
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            vblnk_prev_q <= vblnk_prev_d;
            rgb_s1_q     <= rgb_s1_d;
            blank_s1_q   <= blank_s1_d;
            hit_s1_q     <= hit_s1_d;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign timing_in = '{hcount: hcount_in, vcount: vcount_in,
                         hsync: hsync_in, vsync: vsync_in,
                         hblnk: hblnk_in, vblnk: vblnk_in};

    vga_timing_delay #(
        .N (2)
    ) u_timing_delay (
        .pclk       (pclk),
        .rst        (rst),
        .timing_in  (timing_in),
        .timing_out (timing_out)
    );

    assign hcount_out = timing_out.hcount;
    assign vcount_out = timing_out.vcount;
    assign hsync_out  = timing_out.hsync;
    assign vsync_out  = timing_out.vsync;
    assign hblnk_out  = timing_out.hblnk;
    assign vblnk_out  = timing_out.vblnk;
    assign rgb_out    = rgb_out_q;

endmodule
